axi_ddr_resp_mem: RTL and testbench
===================================

// Module: axi_ddr_resp_mem
// PURPOSE
//  Synthesizable AXI4 slave memory that answers the DDR AXI4 master of qt3_tpu_v1.
//  Serves INCR bursts from an on-chip array. Used for bring-up and for VIP-free simulation.
//  Sits on the aclk domain. Replaces the DDR/VIP slave on the m_axi_* bus.
// PARAMETERS
//  ID_WIDTH        1             AXI ID width
//  DATA_WIDTH      64            data width; beat = DATA_WIDTH/8 bytes
//  B_BURST_LENGTH  8             width of awlen/arlen
//  MEM_WORDS_LOG2  12            array depth = 2**MEM_WORDS_LOG2 words
//  BASE_ADDR       32'h40000000  byte address of word 0
//  GAP_MIN/GAP_MAX 10/20         inter-beat gap range in cycles (AXI_RESP_GAP_EN only)
// PORTS
//  aclk                      in   1       clock
//  aresetn                   in   1       async active-low reset
//  s_axi_awid/arid           in   ID_W    request ID
//  s_axi_awaddr/araddr       in   32      byte address
//  s_axi_awlen/arlen         in   B_BL    beats-1
//  s_axi_awsize/arsize       in   3       beat size
//  s_axi_awburst/arburst     in   2       burst type
//  s_axi_aw/ar{lock,cache,prot,region,qos}  in  1/4/3/4/4  sideband; accepted, ignored
//  s_axi_awvalid/arvalid     in   1       address valid
//  s_axi_awready/arready     out  1       address ready
//  s_axi_wdata               in   DATA_W  write data
//  s_axi_wstrb               in   DATA_W/8  byte enables
//  s_axi_wlast,wvalid        in   1       last beat / valid
//  s_axi_wready              out  1       write data ready
//  s_axi_bid,bresp,bvalid    out  ID_W/2/1  write response
//  s_axi_bready              in   1       response ready
//  s_axi_rid,rdata,rresp     out  ID_W/DATA_W/2  read beat
//  s_axi_rlast,rvalid        out  1       last beat / valid
//  s_axi_rready              in   1       read ready
// BEHAVIOUR
//  Reset: all FSMs IDLE. Every ready/valid/last output is 0; bid/bresp/rid/rresp/rdata are 0.
//   Memory contents are not reset. Reset mid-burst drops the burst silently.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. One outstanding write.
//   W_IDLE: awready=1; on AW handshake latch id, addr, len, err.
//   W_DATA: wready=1. Each W handshake writes wstrb-selected bytes to the word at addr, then addr += DATA_W/8.
//   Beats past len are accepted but not written; they set err.
//   On the wlast beat go to W_RESP; wlast with count!=len sets err.
//   W_RESP: bvalid=1, bid=latched id, bresp=err?SLVERR(2'b10):OKAY. Hold until bready.
//  Read FSM R_IDLE->R_DATA->R_IDLE. One outstanding read.
//   R_IDLE: arready=1. On AR handshake, rvalid=1 next cycle with word(araddr): AR->R latency 1.
//   R_DATA: on each R handshake, rdata loads word(addr+beat) in the same edge, so full throughput.
//   rlast=1 on beat==len. After the rlast handshake return to R_IDLE; arready=1 one cycle later.
//  Array is an async-read reg array. Same-cycle read and write to one word: R returns the old data.
//  Errors, per beat/burst:
//   - Word address outside [BASE_ADDR, BASE_ADDR+2**MEM_WORDS_LOG2*DATA_W/8): read beat gives rdata=0, rresp=SLVERR; write beat dropped, err set.
//   - A burst crossing the top boundary errors only on the out-of-range beats; there is no wrap-around.
//   - size != log2(DATA_W/8) sets err (write) or SLVERR on all beats (read); data is still transferred full-width.
//   - FIXED/WRAP bursts are treated as INCR.
//  Addresses use the low log2(DATA_W/8) bits as ignored (aligned). Read and write FSMs are independent and concurrent.
// CONFIGURATION
//  AXI_RESP_GAP_EN defined: after each W handshake, wready=0 for g cycles.
//   Before each R beat after the first, rvalid=0 for g cycles.
//   g is drawn uniformly in [GAP_MIN,GAP_MAX] from a 16-bit LFSR (seed 16'hACE1, reset-restored); W and R each have their own generator.
//  Undefined: no gaps; wready is continuous in W_DATA and R beats are back-to-back.
// STRUCTURE
//  Package axi_resp_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_FIXED/INCR/WRAP,
//   typedef enum w_state_t {W_IDLE,W_DATA,W_RESP}, r_state_t {R_IDLE,R_DATA}.
//  Sub-module axi_resp_gap_gen (LFSR + down-counter; start pulse in, busy out). Instantiated twice, only under AXI_RESP_GAP_EN.
// TESTING
//  1. AW addr=0x40000000 len=7, 8 beats data=i, wstrb=FF -> one bresp=OKAY with matching bid.
//     Then AR same addr/len -> rdata 0..7, rlast on beat 8, all rresp=OKAY.
//  2. Write 0x1122334455667788 at 0x40000008, then 1 beat wstrb=0x0F data=0xFFFFFFFF
//     -> read gives 0x11223344FFFFFFFF.
//  3. AR addr=0x3FFFFFF8 len=1 -> beat 1 rresp=SLVERR rdata=0, beat 2 (0x40000000) OKAY.
//     AW at 0x50000000 -> bresp=SLVERR, memory unchanged.
//  4. AW len=3 with wlast on beat 2 -> bresp=SLVERR; next AW accepted normally.
//  5. Concurrent AR len=255 and AW len=255 to disjoint ranges, rready toggled randomly
//     -> no beat lost/duplicated, both complete. AXI_RESP_GAP_EN build: every R gap is in 10..20 cycles.
//  6. aresetn low during R_DATA beat 4 -> rvalid=0 asynchronously. After release arready=1, previously written data intact.

Source files
------------

// File: rtl/axi_ddr_resp_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 response memory.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_ddr_resp_mem_if.sv
// AXI4 bus between the DDR master and the response memory.
// Handshake: a beat transfers on a rising clock edge where valid && ready; valid never waits on ready.
interface axi_ddr_resp_mem_if #(
  parameter int ID_WIDTH       = 1,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 8
);
  logic [ID_WIDTH-1:0]       awid;
  logic [31:0]               awaddr;
  logic [B_BURST_LENGTH-1:0] awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awregion;
  logic [3:0]                awqos;
  logic                      awvalid;
  logic                      awready;

  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [ID_WIDTH-1:0]       arid;
  logic [31:0]               araddr;
  logic [B_BURST_LENGTH-1:0] arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arregion;
  logic [3:0]                arqos;
  logic                      arvalid;
  logic                      arready;

  logic [ID_WIDTH-1:0]       rid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ddr_resp_mem_gap_gen.sv
// Random idle-gap generator: a start pulse loads a GAP_MIN..GAP_MAX count drawn from a 16-bit LFSR.
module axi_resp_gap_gen #(
  parameter int GAP_MIN = 10,
  parameter int GAP_MAX = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o
);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] SPAN = 16'(GAP_MAX - GAP_MIN + 1);

  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
    if (start_i) begin
      cnt_d  = 16'(GAP_MIN) + (lfsr_q % SPAN);
      // Galois form of x^16 + x^14 + x^13 + x^11 + 1
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
      cnt_q  <= 16'd0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 16'd0);
endmodule

// File: rtl/axi_ddr_resp_mem.sv
// AXI4 slave memory serving INCR bursts from an on-chip array; independent read and write FSMs.
// Optional inter-beat gaps are enabled by defining AXI_RESP_GAP_EN.
module axi_ddr_resp_mem
  import axi_resp_pkg::*;
#(
  parameter int          ID_WIDTH       = 1,
  parameter int          DATA_WIDTH     = 64,
  parameter int          B_BURST_LENGTH = 8,
  parameter int          MEM_WORDS_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          GAP_MIN        = 10,
  parameter int          GAP_MAX        = 20
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi_ddr_resp_mem_if.slave        s_axi,
  output w_state_t                 w_state_o,
  output r_state_t                 r_state_o
);
  localparam int          STRB_W    = DATA_WIDTH / 8;
  localparam int          ADDR_LSB  = $clog2(STRB_W);
  localparam int          SPAN_LSB  = ADDR_LSB + MEM_WORDS_LOG2;
  localparam int          DEPTH     = 1 << MEM_WORDS_LOG2;
  localparam logic [2:0]  FULL_SIZE = 3'(ADDR_LSB);
  localparam logic [31:0] BEAT_INC  = 32'(STRB_W);
  localparam logic [B_BURST_LENGTH:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Out of reset only from the first clock onward, so every ready is low while aresetn is low.
  logic active_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  logic w_gap_busy, w_gap_start, r_gap_busy, r_gap_start;

  // ---------------- write path ----------------
  w_state_t                  w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]       wid_q, wid_d;
  logic [31:0]               waddr_q, waddr_d;
  logic [B_BURST_LENGTH-1:0] wlen_q, wlen_d;
  logic [B_BURST_LENGTH:0]   wcnt_q, wcnt_d;
  logic                      werr_q, werr_d;
  logic                      mem_we, w_beat_ok, w_hit;
  logic [31:0]               off_w;
  logic [MEM_WORDS_LOG2-1:0] w_idx;

  assign off_w     = waddr_q - BASE_ADDR;
  assign w_hit     = (waddr_q >= BASE_ADDR) && ((off_w >> SPAN_LSB) == 32'd0);
  assign w_idx     = off_w[SPAN_LSB-1:ADDR_LSB];
  assign w_beat_ok = (wcnt_q <= {1'b0, wlen_q});

  always_comb begin
    w_state_d      = w_state_q;
    wid_d          = wid_q;
    waddr_d        = waddr_q;
    wlen_d         = wlen_q;
    wcnt_d         = wcnt_q;
    werr_d         = werr_q;
    mem_we         = 1'b0;
    w_gap_start    = 1'b0;
    s_axi.awready  = 1'b0;
    s_axi.wready   = 1'b0;
    s_axi.bvalid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi.awready = active_q;
        if (active_q && s_axi.awvalid) begin
          wid_d     = s_axi.awid;
          waddr_d   = s_axi.awaddr;
          wlen_d    = s_axi.awlen;
          wcnt_d    = '0;
          werr_d    = (s_axi.awsize != FULL_SIZE);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi.wready = !w_gap_busy;
        if (!w_gap_busy && s_axi.wvalid) begin
          w_gap_start = 1'b1;
          mem_we      = w_beat_ok && w_hit;
          if (!w_beat_ok || !w_hit) werr_d = 1'b1;
          if (wcnt_q != CNT_MAX) wcnt_d = wcnt_q + 1'b1;
          waddr_d = waddr_q + BEAT_INC;
          if (s_axi.wlast) begin
            if (wcnt_q != {1'b0, wlen_q}) werr_d = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem_q[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  assign s_axi.bid   = (w_state_q == W_RESP) ? wid_q : '0;
  assign s_axi.bresp = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read path ----------------
  r_state_t                  r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]       rid_q, rid_d;
  logic [31:0]               raddr_q, raddr_d;
  logic [B_BURST_LENGTH-1:0] rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic                      rsize_err_q, rsize_err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [31:0]               rd_addr, off_r;
  logic                      r_hit, rd_size_err;
  logic [MEM_WORDS_LOG2-1:0] r_idx;
  logic [DATA_WIDTH-1:0]     rd_word;

  // The word fetched at an edge is the AR address when idle, otherwise the next beat's address.
  assign rd_addr     = (r_state_q == R_IDLE) ? s_axi.araddr : raddr_q + BEAT_INC;
  assign off_r       = rd_addr - BASE_ADDR;
  assign r_hit       = (rd_addr >= BASE_ADDR) && ((off_r >> SPAN_LSB) == 32'd0);
  assign r_idx       = off_r[SPAN_LSB-1:ADDR_LSB];
  assign rd_word     = r_hit ? mem_q[r_idx] : '0;
  assign rd_size_err = (r_state_q == R_IDLE) ? (s_axi.arsize != FULL_SIZE) : rsize_err_q;

  always_comb begin
    r_state_d     = r_state_q;
    rid_d         = rid_q;
    raddr_d       = raddr_q;
    rlen_d        = rlen_q;
    rbeat_d       = rbeat_q;
    rsize_err_d   = rsize_err_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    r_gap_start   = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi.arready = active_q;
        if (active_q && s_axi.arvalid) begin
          rid_d       = s_axi.arid;
          raddr_d     = s_axi.araddr;
          rlen_d      = s_axi.arlen;
          rbeat_d     = '0;
          rsize_err_d = rd_size_err;
          rdata_d     = rd_word;
          rresp_d     = (!r_hit || rd_size_err) ? RESP_SLVERR : RESP_OKAY;
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        s_axi.rvalid = !r_gap_busy;
        s_axi.rlast  = (rbeat_q == rlen_q);
        if (!r_gap_busy && s_axi.rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_gap_start = 1'b1;
            rbeat_d     = rbeat_q + 1'b1;
            raddr_d     = rd_addr;
            rdata_d     = rd_word;
            rresp_d     = (!r_hit || rd_size_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q   <= R_IDLE;
      rid_q       <= '0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rbeat_q     <= '0;
      rsize_err_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      r_state_q   <= r_state_d;
      rid_q       <= rid_d;
      raddr_q     <= raddr_d;
      rlen_q      <= rlen_d;
      rbeat_q     <= rbeat_d;
      rsize_err_q <= rsize_err_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign s_axi.rid   = rid_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;

  assign w_state_o = w_state_q;
  assign r_state_o = r_state_q;

`ifdef AXI_RESP_GAP_EN
  axi_resp_gap_gen #(.GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX)) u_w_gap (
    .clk_i(aclk), .rst_ni(aresetn), .start_i(w_gap_start), .busy_o(w_gap_busy)
  );
  axi_resp_gap_gen #(.GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX)) u_r_gap (
    .clk_i(aclk), .rst_ni(aresetn), .start_i(r_gap_start), .busy_o(r_gap_busy)
  );
`else
  assign w_gap_busy = 1'b0;
  assign r_gap_busy = 1'b0;
  logic unused_gap;
  assign unused_gap = w_gap_start ^ r_gap_start;
`endif

  // Sideband, burst type and sub-word address bits carry no meaning for this memory.
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot,
                             s_axi.awregion, s_axi.awqos, s_axi.arburst, s_axi.arlock,
                             s_axi.arcache, s_axi.arprot, s_axi.arregion, s_axi.arqos,
                             off_w[ADDR_LSB-1:0], off_r[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_axi_ddr_resp_mem.sv
// Directed bench for axi_ddr_resp_mem (default build, no inter-beat gaps).
module tb_axi_ddr_resp_mem;
  import axi_resp_pkg::*;

  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  w_state_t w_state;
  r_state_t r_state;

  axi_ddr_resp_mem_if bus ();

  axi_ddr_resp_mem dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_axi    (bus),
    .w_state_o(w_state),
    .r_state_o(r_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: handshake timeout after %0d cycles", tag, TMO);
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int k = 0;
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    while (!bus.awready && k < TMO) begin @(negedge aclk); k++; end
    if (k >= TMO) tmo_fail("aw_handshake");
    @(posedge aclk); #1 bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int k = 0;
    @(negedge aclk);
    bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
    while (!bus.wready && k < TMO) begin @(negedge aclk); k++; end
    if (k >= TMO) tmo_fail("w_handshake");
    @(posedge aclk); #1 bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_get(input string tag, input logic id, input logic [1:0] resp);
    int k = 0;
    @(negedge aclk);
    bus.bready = 1'b1;
    while (!bus.bvalid && k < TMO) begin @(negedge aclk); k++; end
    if (k >= TMO) tmo_fail({tag, "_b_handshake"});
    else begin
      check({tag, "_bid"}, 64'(bus.bid), 64'(id));
      check({tag, "_bresp"}, 64'(bus.bresp), 64'(resp));
    end
    @(posedge aclk); #1 bus.bready = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int k = 0;
    @(negedge aclk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    while (!bus.arready && k < TMO) begin @(negedge aclk); k++; end
    if (k >= TMO) tmo_fail("ar_handshake");
    @(posedge aclk); #1 bus.arvalid = 1'b0;
  endtask

  task automatic r_get(input string tag, input logic id, input logic [63:0] d,
                       input logic [1:0] resp, input logic last);
    int k = 0;
    @(negedge aclk);
    bus.rready = 1'b1;
    while (!bus.rvalid && k < TMO) begin @(negedge aclk); k++; end
    if (k >= TMO) tmo_fail({tag, "_r_handshake"});
    else begin
      check({tag, "_rdata"}, bus.rdata, d);
      check({tag, "_rresp"}, 64'(bus.rresp), 64'(resp));
      check({tag, "_rlast"}, 64'(bus.rlast), 64'(last));
      check({tag, "_rid"}, 64'(bus.rid), 64'(id));
    end
    @(posedge aclk); #1 bus.rready = 1'b0;
  endtask

  function automatic logic [63:0] pat_a(input int i);
    return {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction

  function automatic logic [63:0] pat_b(input int i);
    return {32'hB000_0000 + 32'(i), 32'h5555_0000 ^ 32'(i)};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awregion = '0; bus.awqos = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arregion = '0; bus.arqos = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values
    #1 aresetn = 1'b0;
    #2;
    check("rst_awready", 64'(bus.awready), 0);
    check("rst_arready", 64'(bus.arready), 0);
    check("rst_wready", 64'(bus.wready), 0);
    check("rst_bvalid", 64'(bus.bvalid), 0);
    check("rst_rvalid", 64'(bus.rvalid), 0);
    check("rst_rlast", 64'(bus.rlast), 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rresp_bresp", 64'({bus.rresp, bus.bresp}), 0);
    check("rst_ids", 64'({bus.rid, bus.bid}), 0);
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk); @(negedge aclk);
    check("post_rst_awready", 64'(bus.awready), 1);
    check("post_rst_arready", 64'(bus.arready), 1);

    // 1: 8-beat write then read back, AR->R latency of one cycle
    aw_send(1'b1, 32'h4000_0000, 8'd7, 3'd3);
    for (int i = 0; i < 8; i++) w_beat(64'(i), 8'hFF, i == 7);
    b_get("t1", 1'b1, RESP_OKAY);
    ar_send(1'b1, 32'h4000_0000, 8'd7, 3'd3);
    check("t1_ar_r_latency", 64'(bus.rvalid), 1);
    for (int i = 0; i < 8; i++) r_get("t1", 1'b1, 64'(i), RESP_OKAY, i == 7);

    // 2: byte-strobe merge
    aw_send(1'b0, 32'h4000_0008, 8'd0, 3'd3);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    b_get("t2a", 1'b0, RESP_OKAY);
    aw_send(1'b0, 32'h4000_0008, 8'd0, 3'd3);
    w_beat(64'hDEAD_BEEF_FFFF_FFFF, 8'h0F, 1'b1);
    b_get("t2b", 1'b0, RESP_OKAY);
    ar_send(1'b0, 32'h4000_0008, 8'd0, 3'd3);
    r_get("t2", 1'b0, 64'h1122_3344_FFFF_FFFF, RESP_OKAY, 1'b1);

    // 3: below-base read, out-of-range write, top-boundary crossing
    ar_send(1'b1, 32'h3FFF_FFF8, 8'd1, 3'd3);
    r_get("t3_lo0", 1'b1, 64'h0, RESP_SLVERR, 1'b0);
    r_get("t3_lo1", 1'b1, 64'h0, RESP_OKAY, 1'b1);
    aw_send(1'b0, 32'h5000_0000, 8'd0, 3'd3);
    w_beat(64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1'b1);
    b_get("t3_oor", 1'b0, RESP_SLVERR);
    ar_send(1'b0, 32'h4000_0000, 8'd0, 3'd3);
    r_get("t3_word0", 1'b0, 64'h0, RESP_OKAY, 1'b1);
    aw_send(1'b1, 32'h4000_7FF8, 8'd1, 3'd3);
    w_beat(64'h7777_0000_0000_7777, 8'hFF, 1'b0);
    w_beat(64'h8888_8888_8888_8888, 8'hFF, 1'b1);
    b_get("t3_top_w", 1'b1, RESP_SLVERR);
    ar_send(1'b1, 32'h4000_7FF8, 8'd1, 3'd3);
    r_get("t3_top0", 1'b1, 64'h7777_0000_0000_7777, RESP_OKAY, 1'b0);
    r_get("t3_top1", 1'b1, 64'h0, RESP_SLVERR, 1'b1);

    // Size mismatch: error flagged, data still moved full-width
    ar_send(1'b0, 32'h4000_0010, 8'd0, 3'd2);
    r_get("sz_r", 1'b0, 64'h2, RESP_SLVERR, 1'b1);
    aw_send(1'b0, 32'h4000_0018, 8'd0, 3'd2);
    w_beat(64'h77, 8'hFF, 1'b1);
    b_get("sz_w", 1'b0, RESP_SLVERR);
    ar_send(1'b0, 32'h4000_0018, 8'd0, 3'd3);
    r_get("sz_rb", 1'b0, 64'h77, RESP_OKAY, 1'b1);

    // 4: early wlast, then a normal write; extra beats past len are dropped
    aw_send(1'b1, 32'h4000_0100, 8'd3, 3'd3);
    w_beat(64'hA0, 8'hFF, 1'b0);
    w_beat(64'hA1, 8'hFF, 1'b1);
    b_get("t4_early", 1'b1, RESP_SLVERR);
    aw_send(1'b0, 32'h4000_0108, 8'd0, 3'd3);
    w_beat(64'hB0, 8'hFF, 1'b1);
    b_get("t4_next", 1'b0, RESP_OKAY);
    ar_send(1'b0, 32'h4000_0100, 8'd1, 3'd3);
    r_get("t4_rb0", 1'b0, 64'hA0, RESP_OKAY, 1'b0);
    r_get("t4_rb1", 1'b0, 64'hB0, RESP_OKAY, 1'b1);
    aw_send(1'b0, 32'h4000_0128, 8'd0, 3'd3);
    w_beat(64'h55, 8'hFF, 1'b1);
    b_get("t4_pre", 1'b0, RESP_OKAY);
    aw_send(1'b0, 32'h4000_0120, 8'd0, 3'd3);
    w_beat(64'h66, 8'hFF, 1'b0);
    w_beat(64'h99, 8'hFF, 1'b1);
    b_get("t4_extra", 1'b0, RESP_SLVERR);
    ar_send(1'b0, 32'h4000_0120, 8'd1, 3'd3);
    r_get("t4_ex0", 1'b0, 64'h66, RESP_OKAY, 1'b0);
    r_get("t4_ex1", 1'b0, 64'h55, RESP_OKAY, 1'b1);

    // 5: preload region A, then concurrent 256-beat read of A and write of B
    aw_send(1'b0, 32'h4000_1000, 8'd255, 3'd3);
    for (int i = 0; i < 256; i++) w_beat(pat_a(i), 8'hFF, i == 255);
    b_get("t5_pre", 1'b0, RESP_OKAY);
    fork
      begin
        aw_send(1'b1, 32'h4000_2000, 8'd255, 3'd3);
        for (int i = 0; i < 256; i++) w_beat(pat_b(i), 8'hFF, i == 255);
        b_get("t5_w", 1'b1, RESP_OKAY);
      end
      begin
        int beats = 0;
        int cyc = 0;
        logic [63:0] exp_d;
        for (int i = 0; i < 256; i++) exp_q.push_back(pat_a(i));
        ar_send(1'b0, 32'h4000_1000, 8'd255, 3'd3);
        while (beats < 256 && cyc < 4000) begin
          @(negedge aclk);
          bus.rready = 1'($urandom_range(0, 1));
          if (bus.rvalid && bus.rready) begin
            exp_d = exp_q.pop_front();
            check("t5_rdata", bus.rdata, exp_d);
            check("t5_rlast", 64'(bus.rlast), 64'(beats == 255));
            beats++;
          end
          cyc++;
        end
        @(posedge aclk); #1 bus.rready = 1'b0;
        check("t5_rbeats", 64'(beats), 256);
        check("t5_queue_empty", 64'(exp_q.size()), 0);
        @(negedge aclk);
        check("t5_no_extra_beat", 64'(bus.rvalid), 0);
      end
    join
    ar_send(1'b1, 32'h4000_2000, 8'd1, 3'd3);
    r_get("t5_b0", 1'b1, pat_b(0), RESP_OKAY, 1'b0);
    r_get("t5_b1", 1'b1, pat_b(1), RESP_OKAY, 1'b1);
    ar_send(1'b1, 32'h4000_27F8, 8'd0, 3'd3);
    r_get("t5_b255", 1'b1, pat_b(255), RESP_OKAY, 1'b1);

    // 6: asynchronous reset during beat 4 of a read burst
    ar_send(1'b0, 32'h4000_0000, 8'd7, 3'd3);
    r_get("t6_pre0", 1'b0, 64'h0, RESP_OKAY, 1'b0);
    r_get("t6_pre1", 1'b0, 64'h1122_3344_FFFF_FFFF, RESP_OKAY, 1'b0);
    r_get("t6_pre2", 1'b0, 64'h2, RESP_OKAY, 1'b0);
    @(negedge aclk);
    check("t6_beat4_valid", 64'(bus.rvalid), 1);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_rvalid", 64'(bus.rvalid), 0);
    check("t6_rst_arready", 64'(bus.arready), 0);
    check("t6_rst_rlast", 64'(bus.rlast), 0);
    check("t6_rst_wstate", 64'(w_state), 64'(W_IDLE));
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("t6_arready", 64'(bus.arready), 1);
    check("t6_rstate", 64'(r_state), 64'(R_IDLE));
    ar_send(1'b1, 32'h4000_0000, 8'd3, 3'd3);
    r_get("t6_rb0", 1'b1, 64'h0, RESP_OKAY, 1'b0);
    r_get("t6_rb1", 1'b1, 64'h1122_3344_FFFF_FFFF, RESP_OKAY, 1'b0);
    r_get("t6_rb2", 1'b1, 64'h2, RESP_OKAY, 1'b0);
    r_get("t6_rb3", 1'b1, 64'h77, RESP_OKAY, 1'b1);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
